// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth radix-2 multiplier.
package booth_pkg;

  // Controller states; the encoding is exported on the debug state output.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CLR   = 4'd1,
    LDM   = 4'd2,
    LDQ   = 4'd3,
    EVAL  = 4'd4,
    ADD   = 4'd5,
    SUB   = 4'd6,
    SHIFT = 4'd7,
    DONE  = 4'd8
  } booth_state_e;

  // Polarity of the addsub strobe into the adder/subtractor.
  localparam logic ADDSUB_ADD = 1'b1;
  localparam logic ADDSUB_SUB = 1'b0;

endpackage

// File: rtl/booth_if.sv
// Operand/result bundle between a requester and the multiplier.
// Handshake: the requester raises start (level) and keeps it high; the
// multiplier samples M from bus while in LDM and Q from bus while in LDQ,
// then holds done=1 with product valid until start is dropped. A new
// operation starts only after start has been low for at least one cycle.
interface booth_if #(
  parameter int N = 16
);
  import booth_pkg::*;

  logic             start;
  logic [N-1:0]     bus;
  logic             done;
  logic [2*N-1:0]   product;
  booth_state_e     state;    // debug view of the controller state

  modport master (
    output start,
    output bus,
    input  done,
    input  product,
    input  state
  );

  modport slave (
    input  start,
    input  bus,
    output done,
    output product,
    output state
  );
endinterface

// File: rtl/booth_ctrl.sv
// Booth controller FSM: sequences clear, operand loads and the
// evaluate / add-or-subtract / shift loop, then holds in DONE.
module booth_ctrl (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    q0,
  input  logic                    q1,
  input  logic                    eqz,
  output logic                    lda,
  output logic                    clra,
  output logic                    shfta,
  output logic                    ldq,
  output logic                    clrq,
  output logic                    shftq,
  output logic                    ldm,
  output logic                    clrf,
  output logic                    addsub,
  output logic                    dec,
  output logic                    ldc,
  output logic                    done,
  output booth_pkg::booth_state_e state
);
  import booth_pkg::*;

  booth_state_e state_r;
  booth_state_e state_nx;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // Next-state logic; start is only looked at in IDLE and DONE.
  always_comb begin
    state_nx = state_r;
    unique case (state_r)
      IDLE:  if (start) state_nx = CLR;
      CLR:   state_nx = LDM;
      LDM:   state_nx = LDQ;
      LDQ:   state_nx = EVAL;
      EVAL: begin
        unique case ({q0, q1})
          2'b01:   state_nx = ADD;
          2'b10:   state_nx = SUB;
          default: state_nx = SHIFT;
        endcase
      end
      ADD:   state_nx = SHIFT;
      SUB:   state_nx = SHIFT;
      SHIFT: state_nx = eqz ? DONE : EVAL;
      DONE:  if (!start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore strobes decoded from the current state.
  always_comb begin
    lda    = 1'b0;
    clra   = 1'b0;
    shfta  = 1'b0;
    ldq    = 1'b0;
    clrq   = 1'b0;
    shftq  = 1'b0;
    ldm    = 1'b0;
    clrf   = 1'b0;
    addsub = ADDSUB_SUB;
    dec    = 1'b0;
    ldc    = 1'b0;
    done   = 1'b0;
    unique case (state_r)
      CLR: begin
        clra = 1'b1;
        clrf = 1'b1;
      end
      LDM:   ldm = 1'b1;
      LDQ: begin
        ldq = 1'b1;
        ldc = 1'b1;
      end
      ADD: begin
        lda    = 1'b1;
        addsub = ADDSUB_ADD;
      end
      SUB: begin
        lda    = 1'b1;
        addsub = ADDSUB_SUB;
      end
      SHIFT: begin
        shfta = 1'b1;
        shftq = 1'b1;
        dec   = 1'b1;
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Debug view of the current state.
  always_comb begin
    state = state_r;
  end

endmodule

// File: rtl/booth_datapath.sv
// Booth datapath: accumulator A, multiplier Q, Q-1 flop, multiplicand M,
// bit counter and the shared adder/subtractor. Driven purely by strobes.
module booth_datapath #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   bus,
  input  logic           lda,
  input  logic           clra,
  input  logic           shfta,
  input  logic           ldq,
  input  logic           clrq,
  input  logic           shftq,
  input  logic           ldm,
  input  logic           clrf,
  input  logic           addsub,
  input  logic           dec,
  input  logic           ldc,
  output logic           q0,
  output logic           q1,
  output logic           eqz,
  output logic [2*N-1:0] product
);
  import booth_pkg::*;

  localparam logic [W-1:0] CNT_INIT = W'(N - 1);

  logic [N-1:0] a_r;
  logic [N-1:0] q_r;
  logic [N-1:0] m_r;
  logic         q1_r;
  logic [W-1:0] cnt_r;
  logic [N-1:0] alu;

  // Adder/subtractor result; carry out is dropped (modulo 2^N).
  always_comb begin
    alu = (addsub == ADDSUB_ADD) ? (a_r + m_r) : (a_r - m_r);
  end

  // Accumulator: load from the adder beats clear; shift is arithmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     a_r <= '0;
    else if (lda)   a_r <= alu;
    else if (clra)  a_r <= '0;
    else if (shfta) a_r <= {a_r[N-1], a_r[N-1:1]};
  end

  // Multiplier register: receives A[0] on the right shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q_r <= '0;
    else if (ldq)   q_r <= bus;
    else if (clrq)  q_r <= '0;
    else if (shftq) q_r <= {a_r[0], q_r[N-1:1]};
  end

  // Q-1 flop: captures the bit shifted out of Q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q1_r <= 1'b0;
    else if (clrf)  q1_r <= 1'b0;
    else if (shftq) q1_r <= q_r[0];
  end

  // Multiplicand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   m_r <= '0;
    else if (ldm) m_r <= bus;
  end

  // Bit counter: loaded with N-1, decremented on each non-final shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt_r <= '0;
    else if (ldc)          cnt_r <= CNT_INIT;
    else if (dec && !eqz)  cnt_r <= cnt_r - 1'b1;
  end

  // Status back to the controller and the product view.
  always_comb begin
    q0      = q_r[0];
    q1      = q1_r;
    eqz     = (cnt_r == '0);
    product = {a_r, q_r};
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed Booth radix-2 multiplier: controller plus datapath.
module booth_multiplier #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst_n,
  booth_if.slave bif
);
  import booth_pkg::*;

  logic lda, clra, shfta, ldq, clrq, shftq, ldm, clrf, addsub, dec, ldc;
  logic q0, q1, eqz;

  booth_ctrl u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bif.start),
    .q0     (q0),
    .q1     (q1),
    .eqz    (eqz),
    .lda    (lda),
    .clra   (clra),
    .shfta  (shfta),
    .ldq    (ldq),
    .clrq   (clrq),
    .shftq  (shftq),
    .ldm    (ldm),
    .clrf   (clrf),
    .addsub (addsub),
    .dec    (dec),
    .ldc    (ldc),
    .done   (bif.done),
    .state  (bif.state)
  );

  booth_datapath #(
    .N (N),
    .W (W)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bif.bus),
    .lda     (lda),
    .clra    (clra),
    .shfta   (shfta),
    .ldq     (ldq),
    .clrq    (clrq),
    .shftq   (shftq),
    .ldm     (ldm),
    .clrf    (clrf),
    .addsub  (addsub),
    .dec     (dec),
    .ldc     (ldc),
    .q0      (q0),
    .q1      (q1),
    .eqz     (eqz),
    .product (bif.product)
  );

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier against an arithmetic model.
module tb_booth_multiplier;
  import booth_pkg::*;

  localparam int N = 16;
  localparam int W = 4;
  localparam int TIMEOUT = 200;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  logic [2*N-1:0] exp_q[$];

  booth_if #(.N(N)) bif ();

  booth_multiplier #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2*N-1:0] model_product(input logic [N-1:0] m, input logic [N-1:0] q);
    longint p;
    p = longint'($signed(m)) * longint'($signed(q));
    return p[2*N-1:0];
  endfunction

  // Number of Booth add/sub steps: bit changes in Q scanned LSB-first from 0.
  function automatic int model_arith_steps(input logic [N-1:0] q);
    int   k;
    logic prev;
    k = 0;
    prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (q[i] != prev) k++;
      prev = q[i];
    end
    return k;
  endfunction

  // ---------------- driver ----------------
  // Raise start, feed M/Q when the design asks for them, stop at done.
  task automatic drive_op(input logic [N-1:0] m, input logic [N-1:0] q,
                          output logic [2*N-1:0] prod, output int shifts,
                          output int arith, output int busy, output bit timed_out);
    shifts = 0; arith = 0; busy = 0; timed_out = 1'b1;
    @(negedge clk);
    bif.start = 1'b1;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      if (bif.state == LDM) bif.bus = m;
      if (bif.state == LDQ) bif.bus = q;
      if (bif.state == SHIFT) shifts++;
      if (bif.state == ADD || bif.state == SUB) arith++;
      if (bif.state != IDLE && bif.state != DONE) busy++;
      if (bif.done) begin
        timed_out = 1'b0;
        break;
      end
    end
    prod = bif.product;
  endtask

  task automatic release_start();
    bif.start = 1'b0;
    bif.bus   = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bif.state == IDLE) break;
    end
  endtask

  // Full checked operation through the scoreboard queue.
  task automatic checked_op(input string tag, input logic [N-1:0] m, input logic [N-1:0] q);
    logic [2*N-1:0] prod, expv;
    int shifts, arith, busy, exp_arith;
    bit to;
    exp_q.push_back(model_product(m, q));
    exp_arith = model_arith_steps(q);
    drive_op(m, q, prod, shifts, arith, busy, to);
    expv = exp_q.pop_front();
    n_cmp++;
    if (to) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen in %0d cycles", tag, TIMEOUT);
    end else begin
      if (prod !== expv) begin
        n_fail++;
        $display("FAIL %s product M=%h Q=%h: got %h expected %h", tag, m, q, prod, expv);
      end
      n_cmp++;
      if (shifts != N || arith != exp_arith) begin
        n_fail++;
        $display("FAIL %s steps: got shifts=%0d arith=%0d expected shifts=%0d arith=%0d",
                 tag, shifts, arith, N, exp_arith);
      end
      n_cmp++;
      if (busy != 3 + 2*N + exp_arith) begin
        n_fail++;
        $display("FAIL %s latency: got %0d busy cycles expected %0d", tag, busy, 3 + 2*N + exp_arith);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bif.start = 1'b0;
    bif.bus = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bif.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", bif.done);
    end
    n_cmp++;
    if (bif.product !== '0) begin
      n_fail++; $display("FAIL reset_product: got %h expected 0", bif.product);
    end
    n_cmp++;
    if (bif.state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected IDLE", bif.state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [N-1:0] m_tab [5];
    logic [N-1:0] q_tab [5];
    m_tab = '{16'd4, 16'hFFFD, 16'h7FFF, 16'd1234, 16'h8001};
    q_tab = '{16'd4, 16'd5,    16'h7FFF, 16'd0,    16'h8000};
    for (int i = 0; i < 5; i++) begin
      checked_op($sformatf("directed%0d", i), m_tab[i], q_tab[i]);
      release_start();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] m, q;
    for (int i = 0; i < 20; i++) begin
      do m = N'($urandom_range(0, 16'hFFFF)); while (m == 16'h8000);
      q = N'($urandom_range(0, 16'hFFFF));
      checked_op($sformatf("random%0d", i), m, q);
      release_start();
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    @(negedge clk);
    bif.start = 1'b1;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      if (bif.state == LDM) bif.bus = 16'h0003;
      if (bif.state == LDQ) bif.bus = 16'h5A5A;
      if (bif.state == EVAL) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_fail++; $display("FAIL mid_reset_reach_eval: EVAL not seen in %0d cycles", TIMEOUT);
    end
    #2;
    rst_n = 1'b0;
    bif.start = 1'b0;
    #1;
    n_cmp++;
    if (bif.product !== '0 || bif.done !== 1'b0 || bif.state !== IDLE) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got product=%h done=%b state=%0d expected 0/0/IDLE",
               bif.product, bif.done, bif.state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checked_op("after_reset", 16'hFFFF, 16'hFFFF);
    release_start();
  endtask

  task automatic test_hold_done();
    logic [2*N-1:0] expv;
    checked_op("hold_run", 16'h0123, 16'hFF00);
    expv = model_product(16'h0123, 16'hFF00);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bif.state !== DONE || bif.done !== 1'b1 || bif.product !== expv) begin
        n_fail++;
        $display("FAIL hold_done cycle %0d: got state=%0d done=%b product=%h expected DONE/1/%h",
                 c, bif.state, bif.done, bif.product, expv);
      end
    end
    bif.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bif.state !== IDLE || bif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_start: got state=%0d done=%b expected IDLE/0", bif.state, bif.done);
    end
    checked_op("fresh_run", 16'hFFF9, 16'h000B);
    release_start();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_hold_done();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
